// File: rtl/taus_urng_multi.sv
// Multi-channel taus88 uniform RNG with runtime seed loading, warm-up and gated stepping.
// Define TAUS_SAMPLE_CNT_EN to add oSample_cnt (valid samples emitted since the last start).
module taus_urng_multi #(
    parameter int NUM_CH = 2,
    parameter int WARMUP = 16,
    parameter int CH_W   = 4
) (
    input  logic                  rClk,
    input  logic                  rRst,
    input  logic                  iSeed_wr,
    input  logic [CH_W-1:0]       iSeed_ch,
    input  logic [1:0]            iSeed_idx,
    input  logic [31:0]           iSeed_data,
    input  logic                  iStart,
    input  logic                  iEn,
    output logic [32*NUM_CH-1:0]  oUrng,
    output logic                  oValid,
    output logic                  oBusy,
`ifdef TAUS_SAMPLE_CNT_EN
    output logic [31:0]           oSample_cnt,
`endif
    output logic                  oSeed_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WARM = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]  state;
    logic [7:0]  warm_cnt;
    logic [31:0] seed   [NUM_CH][3];
    logic [31:0] work   [NUM_CH][3];
    logic [31:0] nxt    [NUM_CH][3];
    logic [31:0] sample [NUM_CH];
    logic        seed_ok;
    logic        start_ok;
`ifdef TAUS_SAMPLE_CNT_EN
    logic [31:0] sample_cnt;
`endif

    function automatic logic [31:0] step_s1(input logic [31:0] s);
        logic [31:0] b;
        b = ((s << 13) ^ s) >> 19;
        return ((s & 32'hFFFFFFFE) << 12) ^ b;
    endfunction

    function automatic logic [31:0] step_s2(input logic [31:0] s);
        logic [31:0] b;
        b = ((s << 2) ^ s) >> 25;
        return ((s & 32'hFFFFFFF8) << 4) ^ b;
    endfunction

    function automatic logic [31:0] step_s3(input logic [31:0] s);
        logic [31:0] b;
        b = ((s << 3) ^ s) >> 11;
        return ((s & 32'hFFFFFFF0) << 17) ^ b;
    endfunction

    // Seeds below a component's minimum would lock that LFSR into a short cycle.
    function automatic logic [31:0] fix_seed(input logic [1:0] idx, input logic [31:0] d);
        logic [31:0] lo;
        case (idx)
            2'd0:    lo = 32'd2;
            2'd1:    lo = 32'd8;
            default: lo = 32'd16;
        endcase
        return (d < lo) ? d + lo : d;
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            nxt[k][0] = step_s1(work[k][0]);
            nxt[k][1] = step_s2(work[k][1]);
            nxt[k][2] = step_s3(work[k][2]);
            sample[k] = nxt[k][0] ^ nxt[k][1] ^ nxt[k][2];
        end
    end

    assign seed_ok  = (state != S_WARM) && (32'(iSeed_ch) < 32'(NUM_CH)) && (iSeed_idx != 2'd3);
    assign start_ok = iStart && (state != S_WARM);
    assign oBusy    = (state == S_WARM);
`ifdef TAUS_SAMPLE_CNT_EN
    assign oSample_cnt = sample_cnt;
`endif

    always_ff @(posedge rClk) begin
        if (!rRst) begin
            state     <= S_IDLE;
            warm_cnt  <= '0;
            oUrng     <= '0;
            oValid    <= 1'b0;
            oSeed_err <= 1'b0;
`ifdef TAUS_SAMPLE_CNT_EN
            sample_cnt <= '0;
`endif
            for (int k = 0; k < NUM_CH; k++) begin
                seed[k][0] <= 32'd1999 + 32'(k);
                seed[k][1] <= 32'd2995 + 32'(k);
                seed[k][2] <= 32'd3666 + 32'(k);
                for (int j = 0; j < 3; j++) work[k][j] <= '0;
            end
        end else begin
            oValid    <= 1'b0;
            oSeed_err <= iSeed_wr && !seed_ok;
            // Seed writes touch only the seed bank; a same-cycle start still copies the old value.
            if (iSeed_wr && seed_ok) begin
                for (int k = 0; k < NUM_CH; k++)
                    for (int j = 0; j < 3; j++)
                        if (32'(iSeed_ch) == 32'(k) && 32'(iSeed_idx) == 32'(j))
                            seed[k][j] <= fix_seed(iSeed_idx, iSeed_data);
            end
            if (start_ok) begin
                for (int k = 0; k < NUM_CH; k++)
                    for (int j = 0; j < 3; j++) work[k][j] <= seed[k][j];
                warm_cnt <= '0;
                state    <= (WARMUP == 0) ? S_RUN : S_WARM;
`ifdef TAUS_SAMPLE_CNT_EN
                sample_cnt <= '0;
`endif
            end else begin
                case (state)
                    S_WARM: begin
                        for (int k = 0; k < NUM_CH; k++)
                            for (int j = 0; j < 3; j++) work[k][j] <= nxt[k][j];
                        warm_cnt <= warm_cnt + 8'd1;
                        if (warm_cnt == 8'(WARMUP - 1)) state <= S_RUN;
                    end
                    S_RUN: begin
                        if (iEn) begin
                            for (int k = 0; k < NUM_CH; k++) begin
                                for (int j = 0; j < 3; j++) work[k][j] <= nxt[k][j];
                                oUrng[32*k +: 32] <= sample[k];
                            end
                            oValid <= 1'b1;
`ifdef TAUS_SAMPLE_CNT_EN
                            sample_cnt <= sample_cnt + 32'd1;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_taus_urng_multi.sv
// Directed scoreboard bench for taus_urng_multi against a taus88 reference model.
module tb_taus_urng_multi;

    localparam int NUM_CH = 2;
    localparam int WARMUP = 16;
    localparam int CH_W   = 4;
    localparam int W      = 32 * NUM_CH;

    logic            rClk = 1'b0;
    logic            rRst = 1'b0;
    logic            iSeed_wr = 1'b0;
    logic [CH_W-1:0] iSeed_ch = '0;
    logic [1:0]      iSeed_idx = '0;
    logic [31:0]     iSeed_data = '0;
    logic            iStart = 1'b0;
    logic            iEn = 1'b0;
    logic [W-1:0]    oUrng;
    logic            oValid;
    logic            oBusy;
    logic            oSeed_err;
`ifdef TAUS_SAMPLE_CNT_EN
    logic [31:0]     oSample_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0]  mseed [NUM_CH][3];
    logic [31:0]  mst   [NUM_CH][3];
    logic [W-1:0] exp_q [$];
    logic [31:0]  exp_cnt;

    taus_urng_multi #(.NUM_CH(NUM_CH), .WARMUP(WARMUP), .CH_W(CH_W)) dut (
        .rClk(rClk), .rRst(rRst), .iSeed_wr(iSeed_wr), .iSeed_ch(iSeed_ch),
        .iSeed_idx(iSeed_idx), .iSeed_data(iSeed_data), .iStart(iStart), .iEn(iEn),
        .oUrng(oUrng), .oValid(oValid), .oBusy(oBusy),
`ifdef TAUS_SAMPLE_CNT_EN
        .oSample_cnt(oSample_cnt),
`endif
        .oSeed_err(oSeed_err)
    );

    always #5 rClk = ~rClk;

    function automatic logic [31:0] t1(input logic [31:0] s);
        logic [31:0] b;
        b = ((s << 13) ^ s) >> 19;
        return ((s & 32'hFFFFFFFE) << 12) ^ b;
    endfunction
    function automatic logic [31:0] t2(input logic [31:0] s);
        logic [31:0] b;
        b = ((s << 2) ^ s) >> 25;
        return ((s & 32'hFFFFFFF8) << 4) ^ b;
    endfunction
    function automatic logic [31:0] t3(input logic [31:0] s);
        logic [31:0] b;
        b = ((s << 3) ^ s) >> 11;
        return ((s & 32'hFFFFFFF0) << 17) ^ b;
    endfunction
    function automatic logic [31:0] valid_seed(input int idx, input logic [31:0] d);
        logic [31:0] m;
        m = (idx == 0) ? 32'd2 : (idx == 1) ? 32'd8 : 32'd16;
        return (d < m) ? d + m : d;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge rClk);
        #1;
    endtask

    task automatic default_seeds();
        for (int k = 0; k < NUM_CH; k++) begin
            mseed[k][0] = 32'd1999 + 32'(k);
            mseed[k][1] = 32'd2995 + 32'(k);
            mseed[k][2] = 32'd3666 + 32'(k);
        end
    endtask

    task automatic ref_next(output logic [W-1:0] smp);
        for (int k = 0; k < NUM_CH; k++) begin
            mst[k][0] = t1(mst[k][0]);
            mst[k][1] = t2(mst[k][1]);
            mst[k][2] = t3(mst[k][2]);
            smp[32*k +: 32] = mst[k][0] ^ mst[k][1] ^ mst[k][2];
        end
    endtask

    task automatic ref_reload();
        logic [W-1:0] dummy;
        for (int k = 0; k < NUM_CH; k++)
            for (int j = 0; j < 3; j++) mst[k][j] = mseed[k][j];
        for (int i = 0; i < WARMUP; i++) ref_next(dummy);
        exp_q.delete();
        exp_cnt = 0;
    endtask

    // Compare the current output against the scoreboard; prev is oUrng before the edge.
    task automatic consume(input bit en, input logic [W-1:0] prev);
        chk("valid", W'(oValid), W'(en));
        if (oValid) begin
            n_assert++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL scoreboard_underflow observed=%0d expected=nonzero", exp_q.size());
            end
            if (exp_q.size() != 0) chk("urng", oUrng, exp_q.pop_front());
        end else begin
            chk("urng_hold", oUrng, prev);
        end
        if (en) exp_cnt++;
`ifdef TAUS_SAMPLE_CNT_EN
        chk("sample_cnt", W'(oSample_cnt), W'(exp_cnt));
`endif
    endtask

    task automatic step_en(input bit en);
        logic [W-1:0] prev;
        logic [W-1:0] s;
        prev = oUrng;
        iEn = en;
        if (en) begin
            ref_next(s);
            exp_q.push_back(s);
        end
        cyc();
        consume(en, prev);
    endtask

    task automatic seed_write(input int ch, input int idx, input logic [31:0] d, input bit bad);
        iEn = 1'b0;
        iSeed_wr = 1'b1;
        iSeed_ch = CH_W'(ch);
        iSeed_idx = 2'(idx);
        iSeed_data = d;
        cyc();
        iSeed_wr = 1'b0;
        chk("seed_err_pulse", W'(oSeed_err), W'(bad));
        cyc();
        chk("seed_err_clear", W'(oSeed_err), W'(0));
        if (!bad) mseed[ch][idx] = valid_seed(idx, d);
    endtask

    // Start (optionally with a same-cycle seed write), check warm-up timing, then consume n samples.
    task automatic start_and_run(input int n, input bit wr, input int ch, input int idx,
                                 input logic [31:0] d);
        int busy;
        logic [W-1:0] s;
        logic [W-1:0] prev;
        ref_reload();
        iStart = 1'b1;
        iEn = 1'b1;
        iSeed_wr = wr;
        iSeed_ch = CH_W'(ch);
        iSeed_idx = 2'(idx);
        iSeed_data = d;
        cyc();
        iStart = 1'b0;
        iSeed_wr = 1'b0;
        if (wr) mseed[ch][idx] = valid_seed(idx, d);
        busy = int'(oBusy);
        for (int i = 1; i <= WARMUP; i++) begin
            cyc();
            if (oBusy) busy++;
            chk("warm_valid_low", W'(oValid), W'(0));
        end
        chk("busy_cycles", W'(busy), W'(WARMUP));
        prev = oUrng;
        ref_next(s);
        exp_q.push_back(s);
        cyc();
        chk("busy_low_in_run", W'(oBusy), W'(0));
        consume(1'b1, prev);
        for (int i = 1; i < n; i++) step_en(1'b1);
    endtask

    initial begin
        default_seeds();
        exp_cnt = 0;
        cyc();
        cyc();
        chk("rst_urng", oUrng, '0);
        chk("rst_valid", W'(oValid), W'(0));
        chk("rst_busy", W'(oBusy), W'(0));
        chk("rst_seed_err", W'(oSeed_err), W'(0));
        rRst = 1'b1;
        iEn = 1'b1;
        cyc();
        chk("idle_valid_low", W'(oValid), W'(0));

        start_and_run(10000, 1'b0, 0, 0, 32'd0);

        step_en(1'b1);
        step_en(1'b0);
        step_en(1'b0);
        step_en(1'b1);
        step_en(1'b1);

        seed_write(0, 3, 32'h1234_5678, 1'b1);
        seed_write(NUM_CH, 0, 32'h1234_5678, 1'b1);
        iStart = 1'b1;
        cyc();
        iStart = 1'b0;
        seed_write(0, 0, 32'hDEAD_BEEF, 1'b1);
        iStart = 1'b1;
        cyc();
        iStart = 1'b0;
        chk("start_in_warm_ignored_busy", W'(oBusy), W'(1));
        repeat (WARMUP + 2) cyc();
        start_and_run(50, 1'b0, 0, 0, 32'd0);
        start_and_run(50, 1'b0, 0, 0, 32'd0);

        start_and_run(20, 1'b1, 1, 1, 32'h0000_4321);
        start_and_run(20, 1'b0, 0, 0, 32'd0);

        step_en(1'b1);
        rRst = 1'b0;
        cyc();
        chk("midrst_urng", oUrng, '0);
        chk("midrst_valid", W'(oValid), W'(0));
        chk("midrst_busy", W'(oBusy), W'(0));
        chk("midrst_seed_err", W'(oSeed_err), W'(0));
`ifdef TAUS_SAMPLE_CNT_EN
        chk("midrst_cnt", W'(oSample_cnt), W'(0));
`endif
        rRst = 1'b1;
        default_seeds();
        exp_q.delete();
        iEn = 1'b1;
        cyc();
        chk("post_rst_idle_valid", W'(oValid), W'(0));
        seed_write(0, 0, 32'd0, 1'b0);
        seed_write(0, 2, 32'd5, 1'b0);
        start_and_run(200, 1'b0, 0, 0, 32'd0);

        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/taus_urng_multi.md
Name: taus_urng_multi

Overview:
- Multi-channel Tausworthe (taus88) uniform random number generator.
- Successor to the fixed two-output generator. Channel count, warm-up length and seed validation are parametrised.
- Adds runtime seed loading, a start/restart handshake, and gated stepping with an output-valid flag.
- Feeds Box-Muller/Gaussian noise stages and file-dump benches; each channel emits one 32-bit uniform word per enabled cycle.

Parameters:
- NUM_CH, 2, number of independent generator channels (1..16); each channel holds three 32-bit component states.
- WARMUP, 16, number of discarded steps after start before output is valid (0..255).
- CH_W, 4, width of the channel-select field; must satisfy 2**CH_W >= NUM_CH.

Ports:
- rClk  in  1  clock; all logic on rising edge.
- rRst  in  1  reset, synchronous, active-low.
- iSeed_wr  in  1  seed write strobe.
- iSeed_ch  in  CH_W  target channel for seed write.
- iSeed_idx  in  2  target component (0,1,2); 3 is invalid.
- iSeed_data  in  32  seed value.
- iStart  in  1  single-cycle pulse: load working states from seed registers, begin warm-up.
- iEn  in  1  step enable in RUN.
- oUrng  out  32*NUM_CH  packed outputs; channel k at bits [32k+31:32k].
- oValid  out  1  oUrng holds a fresh sample this cycle.
- oBusy  out  1  high in WARMUP.
- oSeed_err  out  1  one-cycle pulse on a rejected seed write.

Behaviour:
- Reset (rRst=0 at posedge):
  - State goes to IDLE.
  - oUrng=0, oValid=0, oBusy=0, oSeed_err=0.
  - Seed registers load defaults: component 0/1/2 of channel k = 32'd1999+k, 32'd2995+k, 32'd3666+k. Working states are cleared.
- Seed validation on write: stored value = iSeed_data, except when below the component minimum (2, 8, 16 for idx 0/1/2). In that case it is replaced by iSeed_data+minimum. Example: idx0 data 0 is stored as 2.
- Seed writes:
  - Accepted only in IDLE and RUN; they update seed registers only, never working states.
  - Rejected in WARMUP, or when iSeed_ch>=NUM_CH, or when iSeed_idx==3. A rejected write pulses oSeed_err the next cycle and changes no register.
- Step per channel (all channels in parallel, one cycle):
  - b=((s1<<13)^s1)>>19; s1'=((s1&32'hFFFFFFFE)<<12)^b.
  - b=((s2<<2)^s2)>>25; s2'=((s2&32'hFFFFFFF8)<<4)^b.
  - b=((s3<<3)^s3)>>11; s3'=((s3&32'hFFFFFFF0)<<17)^b.
  - Sample = s1'^s2'^s3'. All arithmetic is 32-bit, and shifts discard overflow bits.
- FSM states: IDLE, WARMUP, RUN.
  - IDLE: oValid=0. iStart moves to WARMUP; counter=0; working states <= seed registers.
  - WARMUP: step every cycle regardless of iEn; oValid=0, oBusy=1. After WARMUP steps, go to RUN. If WARMUP=0, go directly IDLE->RUN on iStart with states loaded.
  - RUN: if iEn=1, step, oUrng<=sample, oValid<=1. If iEn=0, hold state and oUrng, oValid<=0.
  - iStart in RUN reloads seeds and re-enters WARMUP, so sequences are reproducible.
  - iStart in WARMUP is ignored.
- Latency: first oValid is asserted WARMUP+1 cycles after the iStart cycle when iEn=1 is held.
- Simultaneous iSeed_wr and iStart in the same cycle: iStart loads the old seed value; the write takes effect for the next start.
- Reset asserted mid-operation overrides everything; run state is lost and seeds return to defaults.

Optional Feature:
- Macro: TAUS_SAMPLE_CNT_EN.
- Defined:
  - Adds output oSample_cnt, 32 bits: counts cycles with oValid=1 since the last start.
  - Cleared on reset and on every accepted iStart; wraps from 32'hFFFFFFFF to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then iStart with default seeds, WARMUP=16, iEn=1 for 10000 cycles -> each oUrng channel matches a C taus88 reference (same seeds, 16 discarded); oValid first rises on cycle 17 after iStart.
- Write ch0 idx0 data 0, then idx2 data 5 in IDLE -> stored 2 and 21; restart output matches the reference with those seeds.
- Write with iSeed_idx=3, with iSeed_ch=NUM_CH, and during WARMUP -> oSeed_err pulses once each; the next sequence is unchanged from the defaults.
- In RUN, toggle iEn 1,0,0,1 -> oValid follows 1,0,0,1 one cycle later; oUrng holds through the gaps; sample order has no skips vs the reference.
- Run 50 samples, pulse iStart -> the post-restart sequence equals the first 50 samples exactly; oBusy is high for 16 cycles.
- Drop rRst for one cycle mid-RUN -> next cycle all outputs 0, state IDLE; with TAUS_SAMPLE_CNT_EN, oSample_cnt is 0.
